i2c_target_port: RTL

I2C_TARGET_PORT -- requirements
Module: i2c_target_port

---
 rtl/i2c_target_port.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_port.sv
// I2C target with an 8-bit register pointer: byte writes go out as single-clk
// pulses, and reads stream rd_data_i from the current pointer.
module i2c_target_port #(
  parameter logic [6:0] ADDRESS = 7'b1010_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] rd_addr_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        got_ack_q, got_ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte;

  // p0/p1: synchronizer, p2: delay flop for edge and condition detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_i; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign rx_byte   = {shift_q[6:0], sda_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    got_ack_d  = got_ack_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    if (wr_valid_q) ptr_d = ptr_q + 8'd1;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == ADDRESS) begin
                  state_d = ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte;
                state_d = PTR_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                state_d    = WDATA_ACK;
              end
            end
          end
        end
        // the drive flag itself tells the first falling edge from the second
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              cnt_d = 3'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_d  = rd_data_i;
                sda_oe_d = ~rd_data_i[7];
                state_d  = RDATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 8'd1;
              got_ack_d = 1'b0;
              cnt_d     = 3'd0;
              state_d   = RDATA_ACK;
            end else begin
              cnt_d    = cnt_q + 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_p1) state_d = IDLE;
            else        got_ack_d = 1'b1;
          end else if (scl_fall && got_ack_q) begin
            shift_d   = rd_data_i;
            sda_oe_d  = ~rd_data_i[7];
            cnt_d     = 3'd0;
            got_ack_d = 1'b0;
            state_d   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      ptr_q      <= 8'd0;
      rw_q       <= 1'b0;
      got_ack_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      got_ack_q  <= got_ack_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda_oe_o   = sda_oe_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rd_addr_o  = ptr_q;
  assign busy_o     = busy_q;

endmodule
